// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared width helpers and lane-slice macro for the multi-port queue
`ifndef QUEUE_PKG_SV
`define QUEUE_PKG_SV

`define LANE(bus, i, w) bus[(i)*(w) +: (w)]

package queue_pkg;

    function automatic int ptr_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

`endif

// File: rtl/queue_ptr_adv.sv
// rtl/queue_ptr_adv.sv - combinational modulo-LENGTH pointer adder
module queue_ptr_adv
    import queue_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int NW     = cnt_width(LENGTH)
) (
    input  logic [ptr_width(LENGTH)-1:0] ptr_i,
    input  logic [NW-1:0]                n_i,
    output logic [ptr_width(LENGTH)-1:0] next_ptr_o
);

    localparam int PW = ptr_width(LENGTH);
    localparam int SW = ((PW > NW) ? PW : NW) + 1;

    logic [SW-1:0] raw_sum;
    logic [SW-1:0] wrapped;

    // A single conditional subtract suffices because n never exceeds LENGTH.
    always_comb begin
        raw_sum    = SW'(ptr_i) + SW'(n_i);
        wrapped    = (raw_sum >= SW'(LENGTH)) ? (raw_sum - SW'(LENGTH)) : raw_sum;
        next_ptr_o = wrapped[PW-1:0];
    end

endmodule

// File: rtl/multi_port_queue.sv
// rtl/multi_port_queue.sv - circular FIFO with lane-packed enqueue and partial dequeue grants
module multi_port_queue
    import queue_pkg::*;
#(
    parameter int LENGTH    = 16,
    parameter int WIDTH     = 32,
    parameter int ENQ_PORTS = 2,
    parameter int DEQ_PORTS = 2,
    parameter int AF_THRESH = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [ENQ_PORTS-1:0]          enq_valid,
    input  logic [ENQ_PORTS*WIDTH-1:0]    enq_data,
    input  logic [$clog2(DEQ_PORTS+1)-1:0] deq_req,
    output logic [DEQ_PORTS-1:0]          deq_valid,
    output logic [DEQ_PORTS*WIDTH-1:0]    deq_data,
    output logic [cnt_width(LENGTH)-1:0]  count,
    output logic                          halt,
    output logic                          almost_full
);

    localparam int PW = ptr_width(LENGTH);
    localparam int CW = cnt_width(LENGTH);

    logic [WIDTH-1:0]           mem_q [LENGTH];
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DEQ_PORTS-1:0]       deq_valid_q, deq_valid_d;
    logic [DEQ_PORTS*WIDTH-1:0] deq_data_q, deq_data_d;
    logic [CW-1:0]              enq_n, deq_n, free_n;
    logic [PW-1:0]              widx [ENQ_PORTS];
    logic [PW-1:0]              ridx [DEQ_PORTS];

    assign free_n      = CW'(LENGTH) - count_q;
    assign halt        = int'(free_n) < ENQ_PORTS;
    assign almost_full = int'(count_q) >= AF_THRESH;

    // Only the unbroken run of valid lanes from lane 0 is accepted.
    always_comb begin
        enq_n = '0;
        if (!halt) begin
            for (int i = 0; i < ENQ_PORTS; i++) begin
                if (enq_valid[i] && (enq_n == CW'(i))) enq_n = CW'(i + 1);
            end
        end
    end

    always_comb begin
        deq_n = '0;
        if (!stall) begin
            deq_n = (int'(deq_req) > DEQ_PORTS) ? CW'(DEQ_PORTS) : CW'(deq_req);
            if (count_q < deq_n) deq_n = count_q;
        end
    end

    for (genvar i = 0; i < ENQ_PORTS; i++) begin : g_widx
        queue_ptr_adv #(.LENGTH(LENGTH), .NW(CW)) u_widx (
            .ptr_i(tail_q), .n_i(CW'(i)), .next_ptr_o(widx[i])
        );
    end

    for (genvar j = 0; j < DEQ_PORTS; j++) begin : g_ridx
        queue_ptr_adv #(.LENGTH(LENGTH), .NW(CW)) u_ridx (
            .ptr_i(head_q), .n_i(CW'(j)), .next_ptr_o(ridx[j])
        );
    end

    queue_ptr_adv #(.LENGTH(LENGTH), .NW(CW)) u_head (
        .ptr_i(head_q), .n_i(deq_n), .next_ptr_o(head_d)
    );

    queue_ptr_adv #(.LENGTH(LENGTH), .NW(CW)) u_tail (
        .ptr_i(tail_q), .n_i(enq_n), .next_ptr_o(tail_d)
    );

    always_comb begin
        deq_valid_d = '0;
        deq_data_d  = '0;
        for (int j = 0; j < DEQ_PORTS; j++) begin
            if (CW'(j) < deq_n) begin
                deq_valid_d[j]               = 1'b1;
                `LANE(deq_data_d, j, WIDTH) = mem_q[ridx[j]];
            end
        end
    end

    assign count_d = count_q + enq_n - deq_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LENGTH; i++) mem_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            deq_valid_q <= '0;
            deq_data_q  <= '0;
        end else if (flush) begin
            for (int i = 0; i < LENGTH; i++) mem_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            deq_valid_q <= '0;
            deq_data_q  <= '0;
        end else begin
            for (int i = 0; i < ENQ_PORTS; i++) begin
                if (CW'(i) < enq_n) mem_q[widx[i]] <= `LANE(enq_data, i, WIDTH);
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            deq_valid_q <= deq_valid_d;
            deq_data_q  <= deq_data_d;
        end
    end

    assign deq_valid = deq_valid_q;
    assign deq_data  = deq_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_multi_port_queue.sv
// tb/tb_multi_port_queue.sv - self-checking bench for multi_port_queue
module tb_multi_port_queue;

    localparam int LENGTH = 16;
    localparam int WIDTH  = 32;
    localparam int ENQ    = 2;
    localparam int DEQ    = 2;
    localparam int AF     = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  enq_valid;
    logic [63:0] enq_data;
    logic [1:0]  deq_req;
    logic [1:0]  deq_valid;
    logic [63:0] deq_data;
    logic [4:0]  count;
    logic        halt;
    logic        almost_full;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq [$];

    typedef struct {
        logic [1:0]  ev;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  dr;
        logic        st;
        logic        fl;
        logic [4:0]  e_cnt;
        logic [1:0]  e_dv;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_halt;
        logic        e_af;
    } vec_t;

    vec_t vecs [12];

    multi_port_queue #(
        .LENGTH(LENGTH), .WIDTH(WIDTH), .ENQ_PORTS(ENQ), .DEQ_PORTS(DEQ), .AF_THRESH(AF)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .enq_valid(enq_valid), .enq_data(enq_data), .deq_req(deq_req),
        .deq_valid(deq_valid), .deq_data(deq_data), .count(count),
        .halt(halt), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_step(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] dr, input logic st, input logic fl);
        enq_valid = ev;
        enq_data  = {d1, d0};
        deq_req   = dr;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
        enq_valid = '0;
        enq_data  = '0;
        deq_req   = '0;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    // Reference FIFO: grants judged on pre-edge occupancy, enqueue all-or-nothing.
    task automatic model_step(input string tag, input logic [1:0] ev, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [1:0] dr);
        int          cnt, d, e;
        logic [31:0] x0, x1;
        logic [1:0]  edv;
        cnt = mq.size();
        d   = (int'(dr) > DEQ) ? DEQ : int'(dr);
        if (d > cnt) d = cnt;
        e = 0;
        if (LENGTH - cnt >= ENQ && ev[0]) e = ev[1] ? 2 : 1;
        x0 = '0; x1 = '0; edv = '0;
        if (d >= 1) begin x0 = mq.pop_front(); edv[0] = 1'b1; end
        if (d >= 2) begin x1 = mq.pop_front(); edv[1] = 1'b1; end
        if (e >= 1) mq.push_back(d0);
        if (e >= 2) mq.push_back(d1);
        drive_step(ev, d0, d1, dr, 1'b0, 1'b0);
        check({tag, ".count"}, count, mq.size());
        check({tag, ".deq_valid"}, deq_valid, edv);
        check({tag, ".lane0"}, deq_data[31:0], x0);
        check({tag, ".lane1"}, deq_data[63:32], x1);
        check({tag, ".halt"}, halt, (LENGTH - mq.size()) < ENQ);
        check({tag, ".almost_full"}, almost_full, mq.size() >= AF);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        enq_valid = '0; enq_data = '0; deq_req = '0;

        vecs[0]  = '{2'b00, 32'h0,    32'h0,    2'd0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[1]  = '{2'b11, 32'hA0,   32'hB0,   2'd0, 1'b0, 1'b0, 5'd2, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[2]  = '{2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 1'b0, 5'd0, 2'b11, 32'hA0, 32'hB0, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 32'hDEAD, 32'hBEEF, 2'd0, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[4]  = '{2'b01, 32'hC1,   32'h0,    2'd0, 1'b0, 1'b0, 5'd1, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[5]  = '{2'b11, 32'hC2,   32'hC3,   2'd0, 1'b0, 1'b0, 5'd3, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[6]  = '{2'b00, 32'h0,    32'h0,    2'd2, 1'b1, 1'b0, 5'd3, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[7]  = '{2'b00, 32'h0,    32'h0,    2'd3, 1'b0, 1'b0, 5'd1, 2'b11, 32'hC1, 32'hC2, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 1'b0, 5'd0, 2'b01, 32'hC3, 32'h0,  1'b0, 1'b0};
        vecs[9]  = '{2'b11, 32'hE0,   32'hE1,   2'd2, 1'b0, 1'b0, 5'd2, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[10] = '{2'b11, 32'hF0,   32'hF1,   2'd2, 1'b0, 1'b1, 5'd0, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};
        vecs[11] = '{2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst.count", count, 0);
        check("rst.deq_valid", deq_valid, 0);
        check("rst.deq_data", deq_data, 0);
        check("rst.halt", halt, 0);
        check("rst.almost_full", almost_full, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 12; v++) begin
            drive_step(vecs[v].ev, vecs[v].d0, vecs[v].d1, vecs[v].dr, vecs[v].st, vecs[v].fl);
            check($sformatf("vec%0d.count", v), count, vecs[v].e_cnt);
            check($sformatf("vec%0d.deq_valid", v), deq_valid, vecs[v].e_dv);
            check($sformatf("vec%0d.lane0", v), deq_data[31:0], vecs[v].e_d0);
            check($sformatf("vec%0d.lane1", v), deq_data[63:32], vecs[v].e_d1);
            check($sformatf("vec%0d.halt", v), halt, vecs[v].e_halt);
            check($sformatf("vec%0d.almost_full", v), almost_full, vecs[v].e_af);
        end

        mq.delete();
        for (int k = 0; k < 7; k++) model_step("fill", 2'b11, 32'h100 + 2*k, 32'h101 + 2*k, 2'd0);
        model_step("fill15", 2'b01, 32'h10E, 32'h0, 2'd0);
        check("full.count15", count, 15);
        check("full.halt", halt, 1);
        check("full.almost_full", almost_full, 1);
        model_step("halted_enq", 2'b11, 32'h999, 32'h998, 2'd1);
        check("halted_enq.count14", count, 14);
        check("halted_enq.halt", halt, 0);
        check("halted_enq.lane0", deq_data[31:0], 32'h100);
        check("halted_enq.almost_full", almost_full, 1);
        for (int k = 0; k < 7; k++) model_step("drain", 2'b00, 32'h0, 32'h0, 2'd2);

        for (int k = 0; k < 12; k++) model_step("wrap", 2'b11, 32'h200 + 2*k, 32'h201 + 2*k, 2'd2);
        model_step("wrap_tail", 2'b00, 32'h0, 32'h0, 2'd2);
        check("wrap.empty", count, 0);

        model_step("pre_rst", 2'b11, 32'h300, 32'h301, 2'd0);
        model_step("pre_rst", 2'b11, 32'h302, 32'h303, 2'd0);
        model_step("pre_rst", 2'b11, 32'h304, 32'h305, 2'd1);
        check("pre_rst.count5", count, 5);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.count", count, 0);
        check("midrst.deq_valid", deq_valid, 0);
        check("midrst.deq_data", deq_data, 0);
        check("midrst.halt", halt, 0);
        check("midrst.almost_full", almost_full, 0);
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        model_step("post_rst", 2'b01, 32'h400, 32'h0, 2'd2);
        model_step("post_rst", 2'b00, 32'h0, 32'h0, 2'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_port_queue.md
Name: multi_port_queue

Overview:
Parametrised circular FIFO that accepts up to ENQ_PORTS entries and retires up to DEQ_PORTS entries per cycle. It is the multi-issue successor of the single-lane instruction/operand queue. It sits between fetch/decode and dispatch in the out-of-order pipeline. It keeps the stall/flush/halt contract of the single-lane queue and adds lane-packed enqueue, partial dequeue grants, an occupancy count and an almost-full warning.

Parameters:
LENGTH, 16, number of entries; must be >= max(ENQ_PORTS, DEQ_PORTS); need not be a power of 2
WIDTH, 32, bits per entry
ENQ_PORTS, 2, enqueue lanes per cycle (1..4)
DEQ_PORTS, 2, dequeue lanes per cycle (1..4)
AF_THRESH, 12, count at or above which almost_full asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  blocks dequeue this cycle
flush  in  1  synchronous clear of all state
enq_valid  in  ENQ_PORTS  per-lane enqueue request
enq_data  in  ENQ_PORTS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
deq_req  in  clog2(DEQ_PORTS+1)  number of entries requested
deq_valid  out  DEQ_PORTS  registered per-lane valid for deq_data
deq_data  out  DEQ_PORTS*WIDTH  registered dequeued entries, oldest in lane 0
count  out  clog2(LENGTH+1)  registered occupancy
halt  out  1  combinational: free slots < ENQ_PORTS
almost_full  out  1  combinational: count >= AF_THRESH

Behaviour:
- Reset (reset==0, async): storage, head, tail and count go to 0; deq_valid=0; deq_data=0.
- Derived outputs after reset: halt=0; almost_full = (AF_THRESH==0).
- flush (sync, priority over all else): same clear as reset; any enqueue/dequeue in that cycle is discarded.
- Enqueue accept count E:
  - E = number of contiguous 1s in enq_valid starting at lane 0; lanes after the first 0 are dropped.
  - E = 0 if halt==1. Enqueue is all-or-nothing per cycle.
  - Lane i is written to (tail+i) mod LENGTH; tail advances by E.
- Dequeue grant count D:
  - D = 0 if stall, else min(deq_req, count, DEQ_PORTS).
  - Lane j captures entry (head+j) mod LENGTH into deq_data at the next edge; deq_valid[j] = (j < D).
  - Lanes j >= D output zero data, valid 0.
  - head advances by D. Latency is 1 cycle from request to data.
- deq_valid is a one-cycle pulse per grant. With stall high, deq_valid=0 and deq_data=0 on the next cycle (no data hold).
- Full/empty are judged on pre-edge count: slots freed by D are not reusable by the same-cycle enqueue. An entry enqueued this cycle cannot be dequeued this cycle.
- count_next = count + E - D; count never exceeds LENGTH and never goes below 0.
- Wrap-around: pointer advance is computed as p+n, minus LENGTH if the sum >= LENGTH. This is valid because n <= LENGTH.
- Reset asserted mid-operation: immediate clear regardless of clk. On release, the first edge behaves as from an empty queue.
- deq_req > DEQ_PORTS is clamped to DEQ_PORTS.

Decomposition:
- Package queue_pkg holds ptr_width(LENGTH) and cnt_width(LENGTH) helper functions and the lane-slice macro for flattened data buses.
- One sub-module, queue_ptr_adv: a combinational modulo-LENGTH pointer adder (ptr, n) -> next_ptr. It is instantiated for head, tail, and each per-lane read/write index.

Test Plan:
1. Reset then idle: count=0, halt=0, almost_full=0, deq_valid=00. Assert reset mid-stream with count=5 -> all outputs 0 immediately, before the next clk edge.
2. enq_valid=11 with data A,B, then deq_req=2 next cycle -> one cycle later deq_valid=11, lane0=A, lane1=B, count 2->0.
3. enq_valid=10 (gap at lane 0) -> nothing written, count unchanged. enq_valid=01 -> one entry written, count+1.
4. Fill to count=15 (LENGTH=16, ENQ_PORTS=2) -> halt=1; an enqueue of 2 is rejected. Same cycle deq_req=1 -> count=14 next cycle, halt=0. almost_full stays 1 at count>=12.
5. Wrap: cycle 24 entries through in pairs so head/tail cross index 15->0 -> FIFO order preserved, no lost or duplicated values.
6. count=3, deq_req=2 with stall=1 -> deq_valid=00 and count=3. Then flush with enq_valid=11 -> count=0, deq_valid=00 next cycle.
